// File: rtl/sample_collector.sv
// Polls each pin controller's SAMPLE_CNT and pushes {index, cnt, sample_bit} into
// the readback FIFO whenever a pin's count has advanced since the previous scan.
module sample_collector #(
  parameter int          NUM_PINS        = 8,
  parameter logic [10:0] BASE_POSITION   = 11'd0,
  parameter logic [7:0]  ADDR_SAMPLE_REG = 8'd7,
  parameter logic [7:0]  ADDR_SAMPLE_CNT = 8'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        clear_overrun,
  output logic        busy,
  output logic        overrun,
  output logic        bus_enable,
  output logic [18:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic [15:0] bus_data_in,
  output logic [31:0] fifo_data,
  output logic        fifo_wr,
  input  logic        fifo_full
);

  localparam int IDX_W = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;

  typedef enum logic [2:0] {
    IDLE, CNT_RQ, CNT_WT, CHECK, REG_RQ, REG_WT, PUSH, NEXT
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  index;
  logic [IDX_W-1:0]  next_index;
  logic [15:0]       cnt;
  logic [15:0]       delta;
  logic [15:0]       last_cnt [NUM_PINS];
  logic [NUM_PINS-1:0] baseline_valid;
  logic [7:0]        index8;
  logic [10:0]       pos;
  logic [10:0]       next_pos;

  assign next_index = (index == IDX_W'(NUM_PINS - 1)) ? '0 : index + 1'b1;
  assign index8     = 8'(index);
  assign pos        = BASE_POSITION + 11'(index);
  assign next_pos   = BASE_POSITION + 11'(next_index);
  // 16-bit subtraction gives the wrap-safe advance of the pin's counter
  assign delta      = cnt - last_cnt[index];

  assign busy    = (state != IDLE);
  assign bus_wr  = 1'b0;
  assign fifo_wr = (state == PUSH) && !fifo_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      index          <= '0;
      cnt            <= '0;
      overrun        <= 1'b0;
      bus_enable     <= 1'b0;
      bus_rd         <= 1'b0;
      bus_addr       <= '0;
      fifo_data      <= '0;
      baseline_valid <= '0;
      for (int i = 0; i < NUM_PINS; i++) last_cnt[i] <= '0;
    end else begin
      // Read strobes are single-cycle; the address returns to 0 with them
      bus_enable <= 1'b0;
      bus_rd     <= 1'b0;
      bus_addr   <= '0;
      if (clear_overrun) overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (run) begin
            index      <= '0;
            bus_enable <= 1'b1;
            bus_rd     <= 1'b1;
            bus_addr   <= {BASE_POSITION, ADDR_SAMPLE_CNT};
            state      <= CNT_RQ;
          end
        end
        CNT_RQ: state <= CNT_WT;
        CNT_WT: begin
          cnt   <= bus_data_in;
          state <= CHECK;
        end
        CHECK: begin
          if (!baseline_valid[index]) begin
            last_cnt[index]       <= cnt;
            baseline_valid[index] <= 1'b1;
            state                 <= NEXT;
          end else if (delta == 16'd0) begin
            state <= NEXT;
          end else begin
            last_cnt[index] <= cnt;
            // Placed after the clear so a simultaneous set wins
            if (delta > 16'd1) overrun <= 1'b1;
            bus_enable <= 1'b1;
            bus_rd     <= 1'b1;
            bus_addr   <= {pos, ADDR_SAMPLE_REG};
            state      <= REG_RQ;
          end
        end
        REG_RQ: state <= REG_WT;
        REG_WT: begin
          fifo_data <= {index8, cnt, 7'b0, bus_data_in[0]};
          state     <= PUSH;
        end
        PUSH: begin
          if (!fifo_full) state <= NEXT;
        end
        NEXT: begin
          index <= next_index;
          if (run) begin
            bus_enable <= 1'b1;
            bus_rd     <= 1'b1;
            bus_addr   <= {next_pos, ADDR_SAMPLE_CNT};
            state      <= CNT_RQ;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_collector.sv
// Directed bench for sample_collector with two behavioural pin controllers
// answering reads one cycle after the strobe.
`timescale 1ns/1ps
module tb_sample_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        clear_overrun;
  logic        busy;
  logic        overrun;
  logic        bus_enable;
  logic [18:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [15:0] bus_data_in;
  logic [31:0] fifo_data;
  logic        fifo_wr;
  logic        fifo_full;

  logic [15:0] cnt0, cnt1;
  logic        reg0, reg1;
  logic [15:0] pin0_q, pin1_q;

  logic [18:0] rd_q[$];
  logic [31:0] push_q[$];
  int bus_wr_seen = 0;
  int full_viol   = 0;
  int addr_viol   = 0;
  int total_cnt   = 0;
  int pass_cnt    = 0;

  always #5 clk = ~clk;

  sample_collector #(
    .NUM_PINS(2),
    .BASE_POSITION(11'd0),
    .ADDR_SAMPLE_REG(8'd7),
    .ADDR_SAMPLE_CNT(8'd8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .run(run),
    .clear_overrun(clear_overrun),
    .busy(busy),
    .overrun(overrun),
    .bus_enable(bus_enable),
    .bus_addr(bus_addr),
    .bus_rd(bus_rd),
    .bus_wr(bus_wr),
    .bus_data_in(bus_data_in),
    .fifo_data(fifo_data),
    .fifo_wr(fifo_wr),
    .fifo_full(fifo_full)
  );

  // Pin controller models: registered read, drive 0 when not selected
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pin0_q <= '0;
      pin1_q <= '0;
    end else begin
      pin0_q <= '0;
      pin1_q <= '0;
      if (bus_enable && bus_rd && bus_addr[18:8] == 11'd0)
        pin0_q <= (bus_addr[7:0] == 8'd8) ? cnt0 : (bus_addr[7:0] == 8'd7) ? {15'b0, reg0} : 16'h0;
      if (bus_enable && bus_rd && bus_addr[18:8] == 11'd1)
        pin1_q <= (bus_addr[7:0] == 8'd8) ? cnt1 : (bus_addr[7:0] == 8'd7) ? {15'b0, reg1} : 16'h0;
    end
  end
  assign bus_data_in = pin0_q | pin1_q;

  always @(negedge clk) begin
    if (bus_rd) rd_q.push_back(bus_addr);
    if (fifo_wr) begin
      push_q.push_back(fifo_data);
      $display("push: fifo_data=%08h overrun=%0b", fifo_data, overrun);
    end
    if (bus_wr) bus_wr_seen++;
    if (fifo_wr && fifo_full) full_viol++;
    if (!bus_rd && bus_addr != 19'd0) addr_viol++;
  end

  task automatic test_reset();
    reset = 1'b0; run = 1'b0; clear_overrun = 1'b0; fifo_full = 1'b0;
    cnt0 = 16'd5; cnt1 = 16'd5; reg0 = 1'b0; reg1 = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, overrun, bus_enable, bus_rd, bus_wr, fifo_wr} !== 6'b0)
      $display("FAIL reset_ctrl: got %b, want 000000", {busy, overrun, bus_enable, bus_rd, bus_wr, fifo_wr});
    else pass_cnt++;
    total_cnt++;
    if (bus_addr !== 19'd0) $display("FAIL reset_addr: got %05h, want 00000", bus_addr);
    else pass_cnt++;
    total_cnt++;
    if (fifo_data !== 32'd0) $display("FAIL reset_fifo_data: got %08h, want 00000000", fifo_data);
    else pass_cnt++;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_first_scan();
    rd_q.delete(); push_q.delete();
    @(posedge clk); #1 run = 1'b1;
    for (int c = 0; c < 100 && rd_q.size() < 4; c++) @(negedge clk);
    total_cnt++;
    if (rd_q.size() < 4) $display("FAIL t1_reads_timeout: got %0d reads, want 4", rd_q.size());
    else pass_cnt++;
    total_cnt++;
    if (rd_q[0] !== 19'h00008) $display("FAIL t1_first_addr: got %05h, want 00008", rd_q[0]);
    else pass_cnt++;
    total_cnt++;
    if (rd_q[1] !== 19'h00108) $display("FAIL t1_second_addr: got %05h, want 00108", rd_q[1]);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL t1_busy: got %b, want 1", busy);
    else pass_cnt++;
    total_cnt++;
    if (push_q.size() != 0) $display("FAIL t1_no_push: got %0d pushes, want 0", push_q.size());
    else pass_cnt++;
  endtask

  task automatic test_single_advance();
    rd_q.delete(); push_q.delete();
    @(posedge clk); #1 cnt1 = 16'd6; reg1 = 1'b1;
    for (int c = 0; c < 100 && push_q.size() < 1; c++) @(negedge clk);
    total_cnt++;
    if (push_q.size() != 1 || push_q[0] !== 32'h01000601)
      $display("FAIL t2_push: got %0d pushes first=%08h, want 1 push 01000601", push_q.size(), push_q[0]);
    else pass_cnt++;
    total_cnt++;
    if (overrun !== 1'b0) $display("FAIL t2_overrun: got %b, want 0", overrun);
    else pass_cnt++;
    total_cnt++;
    if (rd_q.size() < 2 || rd_q[rd_q.size()-2] !== 19'h00108 || rd_q[rd_q.size()-1] !== 19'h00107)
      $display("FAIL t2_read_order: got %05h,%05h, want 00108,00107",
               rd_q[rd_q.size()-2], rd_q[rd_q.size()-1]);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    push_q.delete();
    @(posedge clk); #1 cnt0 = 16'd8; reg0 = 1'b0;
    for (int c = 0; c < 100 && push_q.size() < 1; c++) @(negedge clk);
    total_cnt++;
    if (push_q.size() != 1 || push_q[0] !== 32'h00000800)
      $display("FAIL t3_push: got %0d pushes first=%08h, want 1 push 00000800", push_q.size(), push_q[0]);
    else pass_cnt++;
    total_cnt++;
    if (overrun !== 1'b1) $display("FAIL t3_overrun_set: got %b, want 1", overrun);
    else pass_cnt++;
    @(posedge clk); #1 clear_overrun = 1'b1;
    @(posedge clk); #1 clear_overrun = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (overrun !== 1'b0) $display("FAIL t3_overrun_clear: got %b, want 0", overrun);
    else pass_cnt++;
    repeat (20) @(negedge clk);
    total_cnt++;
    if (push_q.size() != 1) $display("FAIL t3_single_push: got %0d pushes, want 1", push_q.size());
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    push_q.delete();
    @(posedge clk); #1 cnt0 = 16'hFFFF;
    for (int c = 0; c < 100 && push_q.size() < 1; c++) @(negedge clk);
    total_cnt++;
    if (push_q.size() != 1 || push_q[0] !== 32'h00FFFF00)
      $display("FAIL t4_push_ffff: got %0d pushes first=%08h, want 1 push 00ffff00", push_q.size(), push_q[0]);
    else pass_cnt++;
    @(posedge clk); #1 clear_overrun = 1'b1;
    @(posedge clk); #1 clear_overrun = 1'b0;
    push_q.delete();
    cnt0 = 16'h0000; reg0 = 1'b1;
    for (int c = 0; c < 100 && push_q.size() < 1; c++) @(negedge clk);
    total_cnt++;
    if (push_q.size() != 1 || push_q[0] !== 32'h00000001)
      $display("FAIL t4_push_wrap: got %0d pushes first=%08h, want 1 push 00000001", push_q.size(), push_q[0]);
    else pass_cnt++;
    total_cnt++;
    if (overrun !== 1'b0) $display("FAIL t4_overrun: got %b, want 0", overrun);
    else pass_cnt++;
  endtask

  task automatic test_fifo_full();
    int n;
    rd_q.delete(); push_q.delete();
    @(posedge clk); #1 fifo_full = 1'b1; cnt1 = 16'd7; reg1 = 1'b0;
    for (int c = 0; c < 100 && !(rd_q.size() > 0 && rd_q[rd_q.size()-1] == 19'h00107); c++) @(negedge clk);
    total_cnt++;
    if (rd_q.size() == 0 || rd_q[rd_q.size()-1] !== 19'h00107)
      $display("FAIL t5_reg_read: got %05h, want 00107", rd_q[rd_q.size()-1]);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    n = rd_q.size();
    repeat (10) @(negedge clk);
    total_cnt++;
    if (push_q.size() != 0) $display("FAIL t5_stall_push: got %0d pushes, want 0", push_q.size());
    else pass_cnt++;
    total_cnt++;
    if (rd_q.size() != n) $display("FAIL t5_stall_reads: got %0d reads, want %0d", rd_q.size(), n);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL t5_stall_busy: got %b, want 1", busy);
    else pass_cnt++;
    @(posedge clk); #1 fifo_full = 1'b0;
    repeat (10) @(negedge clk);
    total_cnt++;
    if (push_q.size() != 1 || push_q[0] !== 32'h01000700)
      $display("FAIL t5_release_push: got %0d pushes first=%08h, want 1 push 01000700", push_q.size(), push_q[0]);
    else pass_cnt++;
    total_cnt++;
    if (rd_q.size() <= n) $display("FAIL t5_resume: got %0d reads, want more than %0d", rd_q.size(), n);
    else pass_cnt++;
  endtask

  task automatic test_reset_midread();
    for (int c = 0; c < 100 && bus_rd !== 1'b1; c++) @(negedge clk);
    total_cnt++;
    if (bus_rd !== 1'b1) $display("FAIL t6_find_read: got bus_rd=%b, want 1", bus_rd);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({busy, overrun, bus_enable, bus_rd, bus_wr, fifo_wr} !== 6'b0 || bus_addr !== 19'd0 || fifo_data !== 32'd0)
      $display("FAIL t6_async_reset: got ctrl=%b addr=%05h data=%08h, want all 0",
               {busy, overrun, bus_enable, bus_rd, bus_wr, fifo_wr}, bus_addr, fifo_data);
    else pass_cnt++;
    cnt0 = 16'h0003; cnt1 = 16'h0020;
    @(posedge clk); #1 reset = 1'b1;
    rd_q.delete(); push_q.delete();
    repeat (40) @(negedge clk);
    total_cnt++;
    if (push_q.size() != 0 || rd_q.size() < 4)
      $display("FAIL t6_rescan: got %0d pushes %0d reads, want 0 pushes and at least 4 reads", push_q.size(), rd_q.size());
    else pass_cnt++;
    @(posedge clk); #1 run = 1'b0;
    for (int c = 0; c < 40 && busy !== 1'b0; c++) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL t6_idle: got busy=%b, want 0", busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_scan();
    test_single_advance();
    test_overrun();
    test_wrap();
    test_fifo_full();
    test_reset_midread();
    total_cnt++;
    if (bus_wr_seen != 0) $display("FAIL bus_wr_never: got %0d cycles, want 0", bus_wr_seen);
    else pass_cnt++;
    total_cnt++;
    if (full_viol != 0) $display("FAIL fifo_wr_when_full: got %0d cycles, want 0", full_viol);
    else pass_cnt++;
    total_cnt++;
    if (addr_viol != 0) $display("FAIL addr_idle_zero: got %0d cycles, want 0", addr_viol);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
